video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_pkg.sv | 21 ++
 rtl/vtg_axis_ctr.sv | 47 ++++
 rtl/video_timing_gen.sv | 88 ++++++++
 tb/tb_video_timing_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared widths, default VGA 640x480@60 timing constants and counter typedefs
// for the video timing generator.
package video_pkg;

  localparam int PIXEL_CTR_W = 9;
  localparam int LINE_CTR_W  = 9;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [PIXEL_CTR_W:0] pixel_cnt_t;
  typedef logic [LINE_CTR_W:0]  line_cnt_t;

endpackage

// File: rtl/vtg_axis_ctr.sv
// One timing axis: wrapping position counter plus active-area and sync decode.
// Sync is registered from the next count so it lines up with the count itself.
module vtg_axis_ctr #(
  parameter int W      = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active_nxt,
  output logic         sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] cnt_nxt;
  logic         sync_nxt;

  always_comb begin
    wrap    = inc && (cnt == LAST);
    cnt_nxt = cnt;
    if (inc) cnt_nxt = wrap ? '0 : cnt + 1'b1;
    active_nxt = (cnt_nxt < ACT_END);
    sync_nxt   = ((cnt_nxt >= SYNC_LO) && (cnt_nxt <= SYNC_HI)) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= LAST;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, video_on, hsync, vsync.
// Optional frame counter and start-of-frame pulse under VTG_FRAME_CNT_EN.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       rfr_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output pixel_cnt_t pixel_cnt,
  output line_cnt_t  line_cnt,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        sof
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (PIXEL_CTR_W <= 0 || LINE_CTR_W <= 0 ||
      H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_width
    $error("video_timing_gen: zero timing width");
  end
  if (H_TOTAL - 1 >= (1 << (PIXEL_CTR_W + 1))) begin : g_bad_h
    $error("video_timing_gen: H_TOTAL-1 does not fit pixel_cnt");
  end
  if (V_TOTAL - 1 >= (1 << (LINE_CTR_W + 1))) begin : g_bad_v
    $error("video_timing_gen: V_TOTAL-1 does not fit line_cnt");
  end

  logic h_wrap, v_wrap;
  logic h_act_nxt, v_act_nxt;

  vtg_axis_ctr #(
    .W(PIXEL_CTR_W + 1), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h (
    .clk(rfr_clk), .reset_n(reset_n), .inc(pix_en),
    .cnt(pixel_cnt), .wrap(h_wrap), .active_nxt(h_act_nxt), .sync(hsync)
  );

  // Line advances only on the pixel wrap edge.
  vtg_axis_ctr #(
    .W(LINE_CTR_W + 1), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v (
    .clk(rfr_clk), .reset_n(reset_n), .inc(pix_en & h_wrap),
    .cnt(line_cnt), .wrap(v_wrap), .active_nxt(v_act_nxt), .sync(vsync)
  );

  always_ff @(posedge rfr_clk) begin
    if (!reset_n) video_on <= 1'b0;
    else          video_on <= h_act_nxt & v_act_nxt;
  end

`ifdef VTG_FRAME_CNT_EN
  // v_wrap already implies pix_en and h_wrap: the edge into (0,0).
  always_ff @(posedge rfr_clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      sof       <= 1'b0;
    end else begin
      sof <= v_wrap;
      if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a default-timing DUT and a small inverted-polarity DUT
// share stimulus; a behavioural model predicts every edge.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 480, VF = 10, VS = 2,  VB = 33;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB, SVT = SVA + SVF + SVS + SVB;

  logic rfr_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en  = 1'b0;

  pixel_cnt_t pixel_cnt, s_pixel_cnt;
  line_cnt_t  line_cnt,  s_line_cnt;
  logic video_on, hsync, vsync, s_video_on, s_hsync, s_vsync;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt, s_frame_cnt;
  logic sof, s_sof;
`endif

  always #5 rfr_clk = ~rfr_clk;

  video_timing_gen dut (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .pix_en(pix_en),
    .pixel_cnt(pixel_cnt), .line_cnt(line_cnt), .video_on(video_on),
    .hsync(hsync), .vsync(vsync)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(frame_cnt), .sof(sof)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_s (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .pix_en(pix_en),
    .pixel_cnt(s_pixel_cnt), .line_cnt(s_line_cnt), .video_on(s_video_on),
    .hsync(s_hsync), .vsync(s_vsync)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(s_frame_cnt), .sof(s_sof)
`endif
  );

  typedef struct {
    int p, l; bit von, hs, vs; int fc; bit sof;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  exp_t m, sm;
  int n_tests = 0, n_fail = 0;
  int hl_cnt = 0, hl_first = -1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Spec-level model of one generator, pol gives the active sync level.
  function automatic exp_t model(input exp_t c, input bit rst, input bit en,
      input int ha, hf, hs, ht, va, vf, vs, vt, input bit pol);
    exp_t n = c;
    if (rst) begin
      n.p = ht - 1; n.l = vt - 1; n.fc = 0; n.sof = 0;
    end else begin
      n.sof = 0;
      if (en) begin
        if (c.p == ht - 1) begin
          n.p = 0;
          n.l = (c.l == vt - 1) ? 0 : c.l + 1;
          if (c.l == vt - 1) begin n.sof = 1; n.fc = (c.fc + 1) % 65536; end
        end else n.p = c.p + 1;
      end
    end
    n.von = !rst && (n.p < ha) && (n.l < va);
    n.hs  = (n.p >= ha + hf && n.p < ha + hf + hs) ? pol : !pol;
    n.vs  = (n.l >= va + vf && n.l < va + vf + vs) ? pol : !pol;
    return n;
  endfunction

  task automatic step(input bit rst, input bit en);
    exp_t e, se;
    @(negedge rfr_clk);
    reset_n = !rst;
    pix_en  = en;
    m  = model(m,  rst, en, HA, HF, HS, HT, VA, VF, VS, VT, 1'b0);
    sm = model(sm, rst, en, SHA, SHF, SHS, SHT, SVA, SVF, SVS, SVT, 1'b1);
    q.push_back(m);
    sq.push_back(sm);
    @(posedge rfr_clk);
    #1;
    if (q.size() == 0 || sq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e  = q.pop_front();
      se = sq.pop_front();
      chk("pixel_cnt", int'(pixel_cnt), e.p);
      chk("line_cnt",  int'(line_cnt),  e.l);
      chk("video_on",  int'(video_on),  int'(e.von));
      chk("hsync",     int'(hsync),     int'(e.hs));
      chk("vsync",     int'(vsync),     int'(e.vs));
      chk("s_pixel_cnt", int'(s_pixel_cnt), se.p);
      chk("s_line_cnt",  int'(s_line_cnt),  se.l);
      chk("s_video_on",  int'(s_video_on),  int'(se.von));
      chk("s_hsync",     int'(s_hsync),     int'(se.hs));
      chk("s_vsync",     int'(s_vsync),     int'(se.vs));
`ifdef VTG_FRAME_CNT_EN
      chk("frame_cnt",   int'(frame_cnt),   e.fc);
      chk("sof",         int'(sof),         int'(e.sof));
      chk("s_frame_cnt", int'(s_frame_cnt), se.fc);
      chk("s_sof",       int'(s_sof),       int'(se.sof));
`endif
      if (e.l == 1 && en && !rst && hsync == 1'b0) begin
        hl_cnt++;
        if (hl_first < 0) hl_first = int'(pixel_cnt);
      end
    end
  endtask

  initial begin
    m  = '{default: 0};
    sm = '{default: 0};
    // reset with pix_en high: reset wins
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // free-run through two full lines plus a bit
    for (int i = 0; i < 2 * HT + 20; i++) step(1'b0, 1'b1);
    chk("hsync_low_width", hl_cnt, HS);
    chk("hsync_low_start", hl_first, HA + HF);
    // half-rate pixel enable
    for (int i = 0; i < 400; i++) step(1'b0, (i % 2) == 0);
    // random enable covers sof with pix_en low after (0,0)
    for (int i = 0; i < 1500; i++) step(1'b0, 1'($urandom_range(0, 1)));
    // mid-frame reset, with and without pix_en
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 2 * SHT * SVT; i++) step(1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
